fpq_count_to_seg: RTL and testbench

//  Downstream stage of the frequency-meter counter: accepts a binary period/frequency count
//  and drives the two 7-seg digits (seg_LED_1, seg_LED_2) of the UI top. Converts the count
//  to BCD by sequential double-dabble, normalises to the two most significant decimal

---
 rtl/fpq_count_to_seg_if.sv | 22 ++
 rtl/fpq_count_to_seg.sv | 130 +++++++++++++
 tb/tb_fpq_count_to_seg.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fpq_count_to_seg_if.sv
// Count-to-display bus: binary count in, two 7-seg digit words, decade range and update strobe out.
interface fpq_count_to_seg_if #(
  parameter int CNT_W = 24
);
  logic [CNT_W-1:0] cnt_in;
  logic             cnt_valid;
  logic             busy;
  logic [8:0]       seg_LED_1;
  logic [8:0]       seg_LED_2;
  logic [2:0]       range;
  logic             disp_valid;

  modport master (
    output cnt_in, cnt_valid,
    input  busy, seg_LED_1, seg_LED_2, range, disp_valid
  );

  modport slave (
    input  cnt_in, cnt_valid,
    output busy, seg_LED_1, seg_LED_2, range, disp_valid
  );
endinterface

// File: rtl/fpq_count_to_seg.sv
// Binary count to two-digit 7-seg display with decade exponent; sequential double-dabble
// followed by leading-zero normalisation.
//
// state | meaning
// IDLE  | waiting for cnt_valid, outputs hold
// CONV  | double-dabble, one input bit per cycle
// NORM  | shift leading zero digits out, count them in z
// OUT   | register digits/range, pulse disp_valid
module fpq_count_to_seg #(
  parameter int CNT_W  = 24,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fpq_count_to_seg_if.slave     bus
);

  localparam int BW = 4 * DIGITS;
  localparam int TW = $clog2((CNT_W > DIGITS) ? CNT_W : DIGITS);
  localparam int ZW = $clog2(DIGITS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [8:0]    BLANK = 9'h100;
  localparam logic [ZW-1:0] Z_MAX = ZW'(DIGITS - 2);

  logic [1:0]       state;
  logic [CNT_W-1:0] bin;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [TW-1:0]    tmr;
  logic [ZW-1:0]    z;
  logic [3:0]       d1;
  logic [3:0]       d2;
  logic [8:0]       seg1_q;
  logic [8:0]       seg2_q;
  logic [2:0]       rng_q;
  logic             dv_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign d1 = bcd[BW-1 -: 4];
  assign d2 = bcd[BW-5 -: 4];

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bin    <= '0;
      bcd    <= '0;
      tmr    <= '0;
      z      <= '0;
      seg1_q <= BLANK;
      seg2_q <= BLANK;
      rng_q  <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cnt_valid) begin
            bin   <= bus.cnt_in;
            bcd   <= '0;
            z     <= '0;
            tmr   <= TW'(CNT_W - 1);
            state <= CONV;
          end
        end
        CONV: begin
          bcd <= {bcd_adj[BW-2:0], bin[CNT_W-1]};
          bin <= {bin[CNT_W-2:0], 1'b0};
          if (tmr == '0) begin
            tmr   <= TW'(DIGITS - 3);
            state <= NORM;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        NORM: begin
          if (d1 == 4'd0) begin
            bcd <= {bcd[BW-5:0], 4'h0};
            z   <= z + 1'b1;
          end
          if (tmr == '0) state <= OUT;
          else           tmr   <= tmr - 1'b1;
        end
        OUT: begin
          dv_q   <= 1'b1;
          rng_q  <= 3'(Z_MAX - z);
          // only a single-digit value can still have a zero leading digit here
          if (z == Z_MAX && d1 == 4'd0) seg1_q <= BLANK;
          else                          seg1_q <= {2'b00, seg7(d1)};
          seg2_q <= {2'b00, seg7(d2)};
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == CONV) || (state == NORM);
  assign bus.seg_LED_1  = seg1_q;
  assign bus.seg_LED_2  = seg2_q;
  assign bus.range      = rng_q;
  assign bus.disp_valid = dv_q;

endmodule

// File: tb/tb_fpq_count_to_seg.sv
// Scoreboard bench for fpq_count_to_seg: arithmetic decimal model, randomized counts and gaps.
module tb_fpq_count_to_seg;
  localparam int CNT_W = 24;
  localparam int LAT   = 31;

  typedef struct {
    logic [8:0]  s1;
    logic [8:0]  s2;
    logic [2:0]  r;
    int unsigned at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t q[$];
  exp_t e_mon;
  bit          active    = 1'b0;
  int unsigned e0_last   = 0;
  int unsigned free_edge = 0;
  logic [8:0]  last_s1   = 9'h100;
  logic [8:0]  last_s2   = 9'h100;
  logic [2:0]  last_r    = 3'd0;
  logic [31:0] rmask;
  logic [31:0] rval;
  int unsigned dir_vals[5] = '{0, 7, 99, 12345, 16777215};

  fpq_count_to_seg_if #(.CNT_W(CNT_W)) bus ();

  fpq_count_to_seg #(.CNT_W(CNT_W), .DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] enc(input int unsigned d);
    case (d)
      0: enc = 7'h3F;  1: enc = 7'h06;  2: enc = 7'h5B;  3: enc = 7'h4F;  4: enc = 7'h66;
      5: enc = 7'h6D;  6: enc = 7'h7D;  7: enc = 7'h07;  8: enc = 7'h7F;  9: enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  // keep the two leading decimal digits; exponent = number of dropped digits
  function automatic exp_t model(input int unsigned v);
    exp_t e;
    int unsigned p;
    int unsigned n;
    int unsigned top;
    e.at = 0;
    if (v < 10) begin
      e.s1 = 9'h100;
      e.s2 = {2'b00, enc(v)};
      e.r  = 3'd0;
    end else begin
      p = 1;
      n = 0;
      while (v / p >= 100) begin
        p = p * 10;
        n++;
      end
      top  = v / p;
      e.s1 = {2'b00, enc(top / 10)};
      e.s2 = {2'b00, enc(top % 10)};
      e.r  = 3'(n);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic send(input int unsigned v);
    int unsigned e0;
    exp_t e;
    e0 = cyc + 1;
    bus.cnt_in    = v[CNT_W-1:0];
    bus.cnt_valid = 1'b1;
    if (!active || e0 >= free_edge) begin
      e    = model(v);
      e.at = e0 + LAT;
      q.push_back(e);
      active    = 1'b1;
      e0_last   = e0;
      free_edge = e0 + LAT + 1;
    end
    @(negedge clk);
    bus.cnt_valid = 1'b0;
    bus.cnt_in    = CNT_W'($urandom);
  endtask

  task automatic wait_edge_before(input int unsigned target);
    for (int i = 0; i < 200 && cyc + 1 < target; i++) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    check("busy", 32'(bus.busy), 32'(active && cyc >= e0_last && cyc <= e0_last + LAT - 2));
    if (bus.disp_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL disp_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e_mon = q.pop_front();
        check("latency", cyc, e_mon.at);
        last_s1 = e_mon.s1;
        last_s2 = e_mon.s2;
        last_r  = e_mon.r;
      end
    end else begin
      check("disp_valid_level", 32'(bus.disp_valid), 32'(1'b0));
      if (q.size() > 0 && q[0].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_disp: got none expected pulse at cycle %0d", q[0].at);
        e_mon = q.pop_front();
      end
    end
    check("seg_LED_1", 32'(bus.seg_LED_1), 32'(last_s1));
    check("seg_LED_2", 32'(bus.seg_LED_2), 32'(last_s2));
    check("range", 32'(bus.range), 32'(last_r));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cnt_in    = '0;
    bus.cnt_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (dir_vals[i]) begin
      send(dir_vals[i]);
      wait_edge_before(free_edge);
    end

    // second strobe while busy is dropped; next one right after the pulse is taken
    send(12345);
    repeat (4) @(negedge clk);
    send(7);
    wait_edge_before(free_edge);
    send(7);
    wait_edge_before(free_edge);

    // strobe landing in OUT is dropped, strobe on the very next edge is taken
    send(99);
    wait_edge_before(free_edge - 1);
    send(5555);
    send(16777215);
    wait_edge_before(free_edge);

    // reset mid-conversion aborts it
    send(987654);
    repeat (9) @(negedge clk);
    rst       = 1'b1;
    active    = 1'b0;
    free_edge = 0;
    if (q.size() > 0) q.delete(q.size() - 1);
    last_s1 = 9'h100;
    last_s2 = 9'h100;
    last_r  = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    send(12345);
    wait_edge_before(free_edge);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      rmask = (32'h1 << $urandom_range(0, CNT_W)) - 32'h1;
      rval  = $urandom & rmask;
      send(rval);
    end

    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
